// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
// Module   : raster_pkg
// Purpose  : Shared raster constants, line-engine FSM state encoding and a
//            small coordinate helper used by the Bresenham line engine.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package raster_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_ADDR_W = 19;
  localparam int COLOR_W   = 4;
  localparam int COORD_W   = 11;

  // err holds dx+dy plus at most one further dx or dy step, so 13 bits
  // signed cover every 11-bit endpoint pair; e2 is twice that.
  localparam int ERR_W = 13;
  localparam int E2_W  = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } line_state_e;

  // Unsigned distance between two coordinates.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bresenham_line_if.sv
`default_nettype none
// ============================================================================
// Module   : bresenham_line_if
// Purpose  : Command and pixel-output bundle of the line engine.
// Ports    : start_x/start_y/end_x/end_y (endpoints), line_color,
//            line_valid/line_ready (command handshake), w_addr, color_out,
//            en_w (pixel write), line_done (completion pulse).
//            master = command issuer / framebuffer side, slave = line engine.
// Revision : 1.0 - initial release
// ============================================================================
interface bresenham_line_if;
  import raster_pkg::*;

  logic [COORD_W-1:0]   start_x;
  logic [COORD_W-1:0]   start_y;
  logic [COORD_W-1:0]   end_x;
  logic [COORD_W-1:0]   end_y;
  logic [COLOR_W-1:0]   line_color;
  logic                 line_valid;
  logic                 line_ready;
  logic [FB_ADDR_W-1:0] w_addr;
  logic [COLOR_W-1:0]   color_out;
  logic                 en_w;
  logic                 line_done;

  modport master (
    output start_x, start_y, end_x, end_y, line_color, line_valid,
    input  line_ready, w_addr, color_out, en_w, line_done
  );

  modport slave (
    input  start_x, start_y, end_x, end_y, line_color, line_valid,
    output line_ready, w_addr, color_out, en_w, line_done
  );

endinterface
`default_nettype wire

// File: rtl/bresenham_line_fb_addr_calc.sv
`default_nettype none
// ============================================================================
// Module   : fb_addr_calc
// Purpose  : Combinational framebuffer address y*640+x built from shifts
//            (y<<9 + y<<7 + x), no multiplier.
// Ports    : x_i, y_i (pixel coordinates), addr_o (19-bit linear address).
// Revision : 1.0 - initial release
// ============================================================================
module fb_addr_calc
  import raster_pkg::*;
(
  input  logic [COORD_W-1:0]   x_i,
  input  logic [COORD_W-1:0]   y_i,
  output logic [FB_ADDR_W-1:0] addr_o
);

  logic [FB_ADDR_W-1:0] x_ext;
  logic [FB_ADDR_W-1:0] y_ext;

  assign x_ext = {{(FB_ADDR_W-COORD_W){1'b0}}, x_i};
  assign y_ext = {{(FB_ADDR_W-COORD_W){1'b0}}, y_i};

  // Off-screen y values wrap here; the address is unused when en_w is low.
  assign addr_o = (y_ext << 9) + (y_ext << 7) + x_ext;

endmodule
`default_nettype wire

// File: rtl/bresenham_line.sv
`default_nettype none
// ============================================================================
// Module   : bresenham_line
// Purpose  : Bresenham line rasteriser. Accepts one line command in IDLE,
//            spends one SETUP cycle deriving the step terms, then emits one
//            pixel per DRAW cycle and pulses line_done in DONE.
// Ports    : clk, rst (sync, active high), bus (bresenham_line_if.slave):
//            command endpoints/colour with valid/ready, pixel address,
//            colour and write strobe, completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module bresenham_line
  import raster_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  bresenham_line_if.slave  bus
);

  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_LIMIT   = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIMIT   = COORD_W'(V_RES);

  line_state_e state_q, state_d;

  logic [COORD_W-1:0]      x_q, x_d;
  logic [COORD_W-1:0]      y_q, y_d;
  logic [COORD_W-1:0]      x1_q, x1_d;
  logic [COORD_W-1:0]      y1_q, y1_d;
  logic [COLOR_W-1:0]      color_q, color_d;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic signed [ERR_W-1:0] dx_q, dx_d;
  logic signed [ERR_W-1:0] dy_q, dy_d;
  logic                    sx_neg_q, sx_neg_d;
  logic                    sy_neg_q, sy_neg_d;

  logic signed [E2_W-1:0]  e2;
  logic signed [E2_W-1:0]  dx_ext;
  logic signed [E2_W-1:0]  dy_ext;
  logic signed [ERR_W-1:0] err_acc;
  logic                    at_end;
  logic                    on_screen;
  logic [FB_ADDR_W-1:0]    addr;

  assign e2     = {err_q, 1'b0};
  assign dx_ext = {dx_q[ERR_W-1], dx_q};
  assign dy_ext = {dy_q[ERR_W-1], dy_q};
  assign at_end = (x_q == x1_q) && (y_q == y1_q);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    color_d  = color_q;
    err_d    = err_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_acc  = err_q;

    case (state_q)
      ST_IDLE: begin
        // line_ready is high throughout IDLE, so valid alone accepts.
        if (bus.line_valid) begin
          x_d     = bus.start_x;
          y_d     = bus.start_y;
          x1_d    = bus.end_x;
          y1_d    = bus.end_y;
          color_d = bus.line_color;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        dx_d     = $signed({2'b00, abs_diff(x_q, x1_q)});
        dy_d     = -$signed({2'b00, abs_diff(y_q, y1_q)});
        err_d    = dx_d + dy_d;
        sx_neg_d = (x1_q < x_q);
        sy_neg_d = (y1_q < y_q);
        state_d  = ST_DRAW;
      end

      ST_DRAW: begin
        if (at_end) begin
          state_d = ST_DONE;
        end else begin
          // Both tests use the pre-update e2, so a diagonal step may
          // apply both corrections in one cycle.
          if (e2 >= dy_ext) begin
            err_acc = err_acc + dy_q;
            x_d     = sx_neg_q ? (x_q - COORD_ONE) : (x_q + COORD_ONE);
          end
          if (e2 <= dx_ext) begin
            err_acc = err_acc + dx_q;
            y_d     = sy_neg_q ? (y_q - COORD_ONE) : (y_q + COORD_ONE);
          end
          err_d = err_acc;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      err_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      color_q  <= color_d;
      err_q    <= err_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  fb_addr_calc u_fb_addr_calc (
    .x_i    (x_q),
    .y_i    (y_q),
    .addr_o (addr)
  );

  assign on_screen      = (x_q < X_LIMIT) && (y_q < Y_LIMIT);
  assign bus.line_ready = (state_q == ST_IDLE);
  assign bus.en_w       = (state_q == ST_DRAW) && on_screen;
  assign bus.line_done  = (state_q == ST_DONE);
  assign bus.w_addr     = addr;
  assign bus.color_out  = color_q;

endmodule
`default_nettype wire

// File: tb/tb_bresenham_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_bresenham_line
// Purpose  : Self-checking bench for bresenham_line: directed vector table,
//            reset/abort sequences and randomised lines against a pixel-list
//            reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bresenham_line;

  logic clk;
  logic rst;

  bresenham_line_if bus ();

  bresenham_line dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Reference pixel list for the current line.
  int exp_addr[$];
  bit exp_en[$];
  // Observed DRAW cycles for the current line.
  int act_addr[$];
  bit act_en[$];

  typedef struct {
    int       x0, y0, x1, y1, col, npix;
    bit [3:0] en;
    int       addr[4];
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Pixel sequence straight from the Bresenham rules, on plain integers.
  function automatic void model(input int x0, input int y0, input int x1, input int y1);
    int x, y, dx, dy, sx, sy, err, e2;
    exp_addr.delete();
    exp_en.delete();
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    forever begin
      exp_en.push_back((x < 640) && (y < 480));
      exp_addr.push_back(y * 640 + x);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  task automatic drive_cmd(input int x0, input int y0, input int x1, input int y1,
                           input int col, input bit valid);
    bus.start_x    = 11'(x0);
    bus.start_y    = 11'(y0);
    bus.end_x      = 11'(x1);
    bus.end_y      = 11'(y1);
    bus.line_color = 4'(col);
    bus.line_valid = valid;
  endtask

  task automatic drive_noise(input bit valid);
    drive_cmd($urandom_range(0, 2047), $urandom_range(0, 2047),
              $urandom_range(0, 2047), $urandom_range(0, 2047),
              $urandom_range(0, 15), valid);
  endtask

  // Issue one line, follow it to line_done and compare with the model.
  // With noise set, line_valid stays high with junk coordinates while busy.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int col, input bit noise);
    bit done_seen;
    int n, lim;
    model(x0, y0, x1, y1);
    act_addr.delete();
    act_en.delete();
    @(negedge clk);
    drive_cmd(x0, y0, x1, y1, col, 1'b1);
    chk("ready_idle", bus.line_ready, 1);
    @(negedge clk);
    drive_noise(noise);
    chk("setup_ready", bus.line_ready, 0);
    chk("setup_en", bus.en_w, 0);
    chk("setup_done", bus.line_done, 0);
    done_seen = 1'b0;
    for (int c = 0; c < 4200 && !done_seen; c++) begin
      @(negedge clk);
      if (bus.line_done) begin
        done_seen = 1'b1;
        drive_cmd(0, 0, 0, 0, 0, 1'b0);
        chk("done_ready", bus.line_ready, 0);
      end else begin
        act_en.push_back(bus.en_w);
        act_addr.push_back(int'(bus.w_addr));
        if (bus.en_w) chk("pix_color", bus.color_out, col);
        if (bus.line_ready) chk("draw_ready", bus.line_ready, 0);
        if (noise) drive_noise(1'b1);
      end
    end
    chk("done_seen", done_seen, 1);
    lim = (iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0);
    chk("pixel_count", act_en.size(), lim + 1);
    n = (act_en.size() < exp_en.size()) ? act_en.size() : exp_en.size();
    for (int i = 0; i < n; i++) begin
      chk("pix_en", act_en[i], exp_en[i]);
      if (exp_en[i]) chk("pix_addr", act_addr[i], exp_addr[i]);
    end
    @(negedge clk);
    chk("ready_after", bus.line_ready, 1);
    chk("done_pulse_len", bus.line_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int x0, y0, x1, y1;
    tests = 0;
    fails = 0;

    vecs[0] = '{x0:0,   y0:0,   x1:3,   y1:0,   col:5,  npix:4, en:4'b1111, addr:'{0, 1, 2, 3}};
    vecs[1] = '{x0:10,  y0:5,   x1:10,  y1:2,   col:9,  npix:4, en:4'b1111, addr:'{3210, 2570, 1930, 1290}};
    vecs[2] = '{x0:0,   y0:0,   x1:2,   y1:2,   col:12, npix:3, en:4'b0111, addr:'{0, 641, 1282, 0}};
    vecs[3] = '{x0:639, y0:479, x1:639, y1:479, col:3,  npix:1, en:4'b0001, addr:'{307199, 0, 0, 0}};
    vecs[4] = '{x0:638, y0:0,   x1:641, y1:0,   col:15, npix:4, en:4'b0011, addr:'{638, 639, 0, 0}};

    rst = 1'b1;
    drive_cmd(0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.line_ready, 1);
    chk("rst_en", bus.en_w, 0);
    chk("rst_done", bus.line_done, 0);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      run_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col, bit'(i % 2));
      chk("tbl_count", act_en.size(), vecs[i].npix);
      for (int j = 0; j < vecs[i].npix && j < act_en.size(); j++) begin
        chk("tbl_en", act_en[j], vecs[i].en[j]);
        if (vecs[i].en[j]) chk("tbl_addr", act_addr[j], vecs[i].addr[j]);
      end
    end

    // Reset in the middle of a line aborts it silently.
    @(negedge clk);
    drive_cmd(0, 0, 100, 0, 7, 1'b1);
    @(negedge clk);
    drive_cmd(0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_pre_en", bus.en_w, 1);
      chk("abort_pre_addr", bus.w_addr, i);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_en", bus.en_w, 0);
    chk("abort_done", bus.line_done, 0);
    chk("abort_ready", bus.line_ready, 1);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bus.en_w || bus.line_done || !bus.line_ready) bad = 1'b1;
    end
    chk("abort_quiet", bad, 0);

    // Reset wins over a simultaneous command.
    @(negedge clk);
    rst = 1'b1;
    drive_cmd(5, 5, 6, 6, 1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive_cmd(0, 0, 0, 0, 0, 1'b0);
    chk("rstprio_ready", bus.line_ready, 1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.en_w || !bus.line_ready) bad = 1'b1;
    end
    chk("rstprio_quiet", bad, 0);

    // Randomised lines, some straddling the screen edges.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        x0 = $urandom_range(610, 670);
        y0 = $urandom_range(450, 510);
      end else begin
        x0 = $urandom_range(0, 2047);
        y0 = $urandom_range(0, 2047);
      end
      x1 = x0 + $urandom_range(0, 120) - 60;
      y1 = y0 + $urandom_range(0, 120) - 60;
      if (x1 < 0) x1 = 0;
      if (x1 > 2047) x1 = 2047;
      if (y1 < 0) y1 = 0;
      if (y1 > 2047) y1 = 2047;
      run_line(x0, y0, x1, y1, $urandom_range(0, 15), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bresenham_line.md
BRESENHAM_LINE -- requirements
Module: bresenham_line

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start_x, end_x  in  11 each  line endpoint X coordinates, unsigned.
REQ-004 start_y, end_y  in  11 each  line endpoint Y coordinates, unsigned.
REQ-005 line_color  in  4  colour written for every pixel of the line.
REQ-006 line_valid  in  1  line command present on the inputs.
REQ-007 line_ready  out  1  block idle and able to accept a command.
REQ-008 w_addr  out  19  framebuffer write address, y*640+x.
REQ-009 color_out  out  4  pixel colour to the framebuffer controller.
REQ-010 en_w  out  1  framebuffer write strobe, one pixel per cycle.
REQ-011 line_done  out  1  one-cycle pulse at line completion.

Function
REQ-012 FSM states are IDLE, SETUP, DRAW and DONE.
REQ-013 line_ready SHALL be 1 only in IDLE; a command is accepted at a rising edge with line_valid=1 and line_ready=1.
REQ-014 Acceptance latches all four coordinates and line_color and moves IDLE->SETUP; the bench may change the inputs afterwards.
REQ-015 line_valid outside IDLE SHALL be ignored: the command is neither latched nor queued.
REQ-016 SETUP (1 cycle) computes dx=|x1-x0|, dy=-|y1-y0|, sx=+1/-1, sy=+1/-1 and err=dx+dy, then moves to DRAW.
REQ-017 err is 13-bit signed and e2=2*err is 14-bit signed; no overflow is possible for any 11-bit endpoints.
REQ-018 DRAW emits the current (x,y) every cycle.
REQ-019 In DRAW, if (x,y)==(x1,y1), the FSM moves to DONE after this cycle.
REQ-020 Otherwise, in the same cycle: if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy; both updates are applied when both conditions hold.
REQ-021 The pixel count is max(dx,-dy)+1; a zero-length line emits exactly one pixel.
REQ-022 en_w=1 in a DRAW cycle only if x<640 and y<480; off-screen pixels still consume a cycle with en_w=0.
REQ-023 w_addr=(y<<9)+(y<<7)+x, combinational from the current x,y (no multiplier); color_out=latched colour.
REQ-024 w_addr and color_out are don't-care when en_w=0.
REQ-025 DONE lasts 1 cycle: line_done=1, then IDLE; line_ready=1 in the next cycle.
REQ-026 Timing: acceptance edge N, SETUP in cycle N+1, first pixel in cycle N+2, line_done in cycle N+2+count.
REQ-027 The framebuffer has no backpressure; the block never stalls inside DRAW.

Reset
REQ-028 While rst=1, at the rising edge: state=IDLE, en_w=0, line_done=0, line_ready=1 on the following cycle, internal x/y/err=0.
REQ-029 Reset in SETUP, DRAW or DONE aborts the line with no further pixels and no line_done pulse.
REQ-030 rst has priority over line_valid in the same cycle.

Structure
REQ-031 Shared package raster_pkg holds H_RES=640, V_RES=480, FB_ADDR_W=19, COLOR_W=4, COORD_W=11 and the FSM state enum.
REQ-032 Sub-module fb_addr_calc (combinational x,y -> 19-bit address via shifts) is the only instantiated child.

Verification
REQ-033 Horizontal: (0,0)->(3,0), colour 5 -> en_w addrs 0,1,2,3 in consecutive cycles, colour 5, line_done the next cycle.
REQ-034 Vertical, reverse direction: (10,5)->(10,2) -> addrs 3210, 2570, 1930, 1290, then line_done.
REQ-035 Diagonal: (0,0)->(2,2) -> addrs 0, 641, 1282; line_ready low from acceptance until line_done+1.
REQ-036 Point: (639,479)->(639,479) -> one pixel at addr 307199, line_done in cycle N+3.
REQ-037 Clip: (638,0)->(641,0) -> 4 DRAW cycles, en_w only for addrs 638 and 639, then line_done.
REQ-038 Reset mid-line: start (0,0)->(100,0) and assert rst after 10 pixels -> en_w=0 from the next cycle, no line_done, line_ready=1.
